xmem_bus_ctrl: RTL and testbench



---
 rtl/xmem_bus_ctrl.sv | 167 ++++++++++++++++
 tb/tb_xmem_bus_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_bus_ctrl.sv
// xmem_bus_ctrl: turns the asynchronous AVR XMEM nRD/nWR strobes into
// single-cycle register-file read/write strobes inside the clk domain,
// drives read data back onto the AD bus, and keeps 16-bit register pairs
// atomic through a read shadow (encoders) and a write shadow (servos).
module xmem_bus_ctrl #(
   parameter logic [7:0]  PAGE        = 8'h11,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  RDPAIR_LO   = 8'h0C,
   parameter logic [7:0]  RDPAIR_HI   = 8'h13,
   parameter logic [7:0]  WRPAIR_LO   = 8'h20,
   parameter logic [7:0]  WRPAIR_HI   = 8'h2B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        nRD,
   input  logic        nWR,
   input  logic [7:0]  ad_in,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   output logic [7:0]  reg_addr,
   output logic        reg_re,
   input  logic [15:0] reg_rdata,
   output logic        reg_we,
   output logic [15:0] reg_wdata,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_DATA,
      RD_DRIVE,
      WR_CAP,
      RECOVER
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] rd_sync;
   logic [SYNC_STAGES-1:0] wr_sync;
   logic                   rd_s;
   logic                   wr_s;
   logic                   rd_s_q;
   logic                   wr_s_q;
   logic                   rd_fall;
   logic                   wr_fall;
   logic                   hit;
   logic                   drive_q;
   logic                   rd_vld;
   logic [7:0]             rd_shadow;
   logic [7:0]             wr_shadow;
   logic [7:0]             off;
   logic                   off_rd_win;
   logic                   off_wr_win;
   logic                   q_rd_win;

   function automatic logic in_win(input logic [7:0] o, input logic [7:0] lo,
                                   input logic [7:0] hi);
      return (o >= lo) && (o <= hi);
   endfunction

   assign rd_s       = rd_sync[SYNC_STAGES-1];
   assign wr_s       = wr_sync[SYNC_STAGES-1];
   assign rd_fall    = rd_s_q & ~rd_s;
   assign wr_fall    = wr_s_q & ~wr_s;
   assign hit        = (addr[15:8] == PAGE) & ~addr[15];
   assign off        = addr[7:0];
   assign off_rd_win = in_win(off, RDPAIR_LO, RDPAIR_HI);
   assign off_wr_win = in_win(off, WRPAIR_LO, WRPAIR_HI);
   assign q_rd_win   = in_win(reg_addr, RDPAIR_LO, RDPAIR_HI);

   // Raw nRD gates the enable so the bus is released as soon as the AVR lets go.
   assign ad_oe = drive_q & ~nRD;

   // Strobe synchronisers plus one delay flop each for fall-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sync <= '1;
         wr_sync <= '1;
         rd_s_q  <= 1'b1;
         wr_s_q  <= 1'b1;
      end else begin
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], nRD};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], nWR};
         rd_s_q  <= rd_s;
         wr_s_q  <= wr_s;
      end
   end

   // Access sequencer: issues strobes, manages shadows and the bus drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ad_out    <= '0;
         drive_q   <= 1'b0;
         reg_addr  <= '0;
         reg_re    <= 1'b0;
         reg_we    <= 1'b0;
         reg_wdata <= '0;
         bus_err   <= 1'b0;
         rd_vld    <= 1'b0;
         rd_shadow <= '0;
         wr_shadow <= '0;
      end else begin
         reg_re <= 1'b0;
         reg_we <= 1'b0;
         case (state)
            IDLE: begin
               if (hit && !rd_s && !wr_s) begin
                  bus_err <= 1'b1;
                  state   <= RECOVER;
               end else if (hit && rd_fall) begin
                  state <= RD_ISSUE;
               end else if (hit && wr_fall) begin
                  state <= WR_CAP;
               end
            end
            RD_ISSUE: begin
               reg_addr <= off;
               if (off[0] && off_rd_win && rd_vld) begin
                  ad_out  <= rd_shadow;
                  rd_vld  <= 1'b0;
                  drive_q <= 1'b1;
                  state   <= RD_DRIVE;
               end else begin
                  reg_re <= 1'b1;
                  state  <= RD_DATA;
               end
            end
            RD_DATA: begin
               ad_out  <= reg_rdata[7:0];
               drive_q <= 1'b1;
               if (!reg_addr[0] && q_rd_win) begin
                  rd_shadow <= reg_rdata[15:8];
                  rd_vld    <= 1'b1;
               end
               state <= RD_DRIVE;
            end
            RD_DRIVE: begin
               if (rd_s) begin
                  drive_q <= 1'b0;
                  state   <= RECOVER;
               end
            end
            WR_CAP: begin
               reg_addr <= off;
               if (off_wr_win && !off[0]) begin
                  wr_shadow <= ad_in;
               end else if (off_wr_win) begin
                  reg_wdata <= {ad_in, wr_shadow};
                  reg_we    <= 1'b1;
               end else begin
                  reg_wdata <= {8'h00, ad_in};
                  reg_we    <= 1'b1;
               end
               state <= RECOVER;
            end
            RECOVER: begin
               drive_q <= 1'b0;
               if (rd_s && wr_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xmem_bus_ctrl.sv
// tb_xmem_bus_ctrl: directed and randomized XMEM accesses against a
// transaction-level model of the pair-shadow rules.
module tb_xmem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        nRD;
   logic        nWR;
   logic [7:0]  ad_in;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  reg_addr;
   logic        reg_re;
   logic [15:0] reg_rdata;
   logic        reg_we;
   logic [15:0] reg_wdata;
   logic        bus_err;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned re_cnt   = 0;
   int unsigned we_cnt   = 0;
   logic [7:0]  last_raddr;
   logic [7:0]  last_waddr;
   logic [15:0] last_wdata;

   // transaction-level model state
   logic [7:0]  m_rd_shadow;
   logic        m_rd_vld;
   logic [7:0]  m_wr_shadow;

   xmem_bus_ctrl #(
      .PAGE(8'h11),
      .SYNC_STAGES(2),
      .RDPAIR_LO(8'h0C),
      .RDPAIR_HI(8'h13),
      .WRPAIR_LO(8'h20),
      .WRPAIR_HI(8'h2B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .addr(addr),
      .nRD(nRD),
      .nWR(nWR),
      .ad_in(ad_in),
      .ad_out(ad_out),
      .ad_oe(ad_oe),
      .reg_addr(reg_addr),
      .reg_re(reg_re),
      .reg_rdata(reg_rdata),
      .reg_we(reg_we),
      .reg_wdata(reg_wdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // strobe monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (reg_re) begin
         re_cnt     = re_cnt + 1;
         last_raddr = reg_addr;
      end
      if (reg_we) begin
         we_cnt     = we_cnt + 1;
         last_waddr = reg_addr;
         last_wdata = reg_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_rd_shadow = 8'h00;
      m_rd_vld    = 1'b0;
      m_wr_shadow = 8'h00;
   endtask

   task automatic do_read(input logic [15:0] a, input logic [15:0] rd, output logic [7:0] got);
      logic        h;
      logic        win;
      logic [7:0]  o;
      logic [7:0]  exp;
      logic        exp_re;
      int unsigned re0;
      h      = (a[15:8] == 8'h11);
      o      = a[7:0];
      win    = (o >= 8'h0C) && (o <= 8'h13);
      exp    = 8'h00;
      exp_re = 1'b0;
      if (h) begin
         if (win && o[0] && m_rd_vld) begin
            exp      = m_rd_shadow;
            m_rd_vld = 1'b0;
         end else begin
            exp    = rd[7:0];
            exp_re = 1'b1;
            if (win && !o[0]) begin
               m_rd_shadow = rd[15:8];
               m_rd_vld    = 1'b1;
            end
         end
      end
      @(negedge clk);
      addr      = a;
      reg_rdata = rd;
      re0       = re_cnt;
      nRD       = 1'b0;
      repeat (8) @(negedge clk);
      got = ad_out;
      check("rd_oe", 32'(ad_oe), 32'(h));
      if (h) begin
         check("rd_data", 32'(ad_out), 32'(exp));
         check("rd_addr", 32'(reg_addr), 32'(o));
      end
      nRD = 1'b1;
      #1;
      check("rd_oe_release", 32'(ad_oe), 32'd0);
      repeat (6) @(negedge clk);
      check("rd_re_count", re_cnt - re0, 32'(exp_re));
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      logic        h;
      logic        win;
      logic [7:0]  o;
      logic        exp_we;
      logic [15:0] exp_wd;
      int unsigned we0;
      h      = (a[15:8] == 8'h11);
      o      = a[7:0];
      win    = (o >= 8'h20) && (o <= 8'h2B);
      exp_we = 1'b0;
      exp_wd = 16'h0000;
      if (h) begin
         if (win && !o[0]) begin
            m_wr_shadow = d;
         end else if (win) begin
            exp_we = 1'b1;
            exp_wd = {d, m_wr_shadow};
         end else begin
            exp_we = 1'b1;
            exp_wd = {8'h00, d};
         end
      end
      @(negedge clk);
      addr  = a;
      ad_in = d;
      we0   = we_cnt;
      nWR   = 1'b0;
      repeat (6) @(negedge clk);
      check("wr_oe", 32'(ad_oe), 32'd0);
      nWR = 1'b1;
      repeat (6) @(negedge clk);
      check("wr_we_count", we_cnt - we0, 32'(exp_we));
      if (exp_we) begin
         check("wr_wdata", 32'(last_wdata), 32'(exp_wd));
         check("wr_addr", 32'(last_waddr), 32'(o));
      end
   endtask

   function automatic logic [15:0] rand_addr();
      logic [7:0] up;
      logic [7:0] lo;
      int unsigned sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) lo = 8'($urandom_range(8'h0C, 8'h13));
      else if (sel == 1) lo = 8'($urandom_range(8'h20, 8'h2B));
      else lo = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
         up = 8'($urandom);
         if (up == 8'h11) up = 8'h21;
      end else begin
         up = 8'h11;
      end
      return {up, lo};
   endfunction

   initial begin
      logic [7:0]  g;
      int unsigned re0;
      int unsigned we0;
      rst       = 1'b1;
      addr      = 16'h0000;
      nRD       = 1'b1;
      nWR       = 1'b1;
      ad_in     = 8'h00;
      reg_rdata = 16'h0000;
      model_reset();
      repeat (4) @(negedge clk);
      check("rst_ad_out", 32'(ad_out), 32'd0);
      check("rst_ad_oe", 32'(ad_oe), 32'd0);
      check("rst_reg_re", 32'(reg_re), 32'd0);
      check("rst_reg_we", 32'(reg_we), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // plain write, then a write off the page
      do_write(16'h1101, 8'h5A);
      check("tp_wr_plain", 32'(last_wdata), 32'h005A);
      do_write(16'h2101, 8'h77);

      // atomic servo pair write
      we0 = we_cnt;
      do_write(16'h1120, 8'h34);
      check("tp_wr_lo_no_we", we_cnt - we0, 32'd0);
      do_write(16'h1121, 8'h82);
      check("tp_wr_pair", 32'(last_wdata), 32'h8234);

      // atomic encoder pair read
      re0 = re_cnt;
      do_read(16'h110C, 16'hBEEF, g);
      check("tp_rd_lo", 32'(g), 32'hEF);
      do_read(16'h110D, 16'h1234, g);
      check("tp_rd_hi_shadow", 32'(g), 32'hBE);
      check("tp_rd_pair_re", re_cnt - re0, 32'd1);
      do_read(16'h110D, 16'h5678, g);
      check("tp_rd_hi_direct", 32'(g), 32'h78);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 0) do_read(rand_addr(), 16'($urandom), g);
         else do_write(rand_addr(), 8'($urandom));
      end
      check("rand_no_bus_err", 32'(bus_err), 32'd0);

      // both strobes low together on a hit
      re0 = re_cnt;
      we0 = we_cnt;
      @(negedge clk);
      addr = 16'h1105;
      nRD  = 1'b0;
      nWR  = 1'b0;
      repeat (8) @(negedge clk);
      check("err_flag", 32'(bus_err), 32'd1);
      check("err_oe", 32'(ad_oe), 32'd0);
      check("err_no_re", re_cnt - re0, 32'd0);
      check("err_no_we", we_cnt - we0, 32'd0);
      nRD = 1'b1;
      nWR = 1'b1;
      repeat (6) @(negedge clk);
      do_write(16'h1102, 8'h11);
      check("err_sticky", 32'(bus_err), 32'd1);

      // reset in the middle of a driven read
      do_read(16'h110C, 16'hA55A, g);
      do_write(16'h1120, 8'h66);
      @(negedge clk);
      addr      = 16'h1101;
      reg_rdata = 16'h00C3;
      nRD       = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_oe_before", 32'(ad_oe), 32'd1);
      check("mid_data_before", 32'(ad_out), 32'hC3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_oe", 32'(ad_oe), 32'd0);
      check("mid_rst_ad_out", 32'(ad_out), 32'd0);
      check("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
      check("mid_rst_wdata", 32'(reg_wdata), 32'd0);
      check("mid_rst_bus_err", 32'(bus_err), 32'd0);
      @(negedge clk);
      nRD = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      re0 = re_cnt;
      do_read(16'h110D, 16'h7788, g);
      check("post_rst_rd_vld_clear", 32'(g), 32'h88);
      check("post_rst_rd_re", re_cnt - re0, 32'd1);
      do_write(16'h1121, 8'h44);
      check("post_rst_wr_shadow_clear", 32'(last_wdata), 32'h4400);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
